risc_spm_control_unit: RTL and testbench

- Moore-style sequencer for the RISC-SPM datapath.
- Drives the per-register load strobes of the general purpose registers R0-R3, plus PC, IR, Add_R, Reg_Y and Reg_Z loads, the Bus_1/Bus_2 mux selects and the memory write strobe.
- Walks fetch/decode/execute per instruction from the opcode in IR and the ALU zero flag.
- Sits beside the datapath in the processor top; the ALU takes its opcode directly from IR, not from this block.

---
 rtl/risc_spm_pkg.sv | 53 +++++
 rtl/risc_spm_control_unit.sv | 205 ++++++++++++++++++++
 tb/tb_risc_spm_control_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/risc_spm_pkg.sv
// Shared encodings for the RISC-SPM sequencer: opcodes, FSM states, bus selects.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package risc_spm_pkg;

  // Opcode field values (instruction[7:4]); 9..15 are illegal
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;

  // Sequencer states; encodings 12..15 are unused and recover to S_idle
  typedef enum logic [3:0] {
    S_idle = 4'd0,
    S_fet1 = 4'd1,
    S_fet2 = 4'd2,
    S_dec  = 4'd3,
    S_ex1  = 4'd4,
    S_rd1  = 4'd5,
    S_rd2  = 4'd6,
    S_wr1  = 4'd7,
    S_wr2  = 4'd8,
    S_br1  = 4'd9,
    S_br2  = 4'd10,
    S_halt = 4'd11
  } state_t;

  // Bus_1 source selects
  localparam logic [2:0] SEL1_R0 = 3'd0;
  localparam logic [2:0] SEL1_R1 = 3'd1;
  localparam logic [2:0] SEL1_R2 = 3'd2;
  localparam logic [2:0] SEL1_R3 = 3'd3;
  localparam logic [2:0] SEL1_PC = 3'd4;

  // Bus_2 source selects
  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;

  // One-hot load strobe for general purpose register R[idx]
  function automatic logic [3:0] reg_load_mask(input logic [1:0] idx);
    logic [3:0] m;
    m = 4'b0000;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/risc_spm_control_unit.sv
// Moore sequencer for the RISC-SPM datapath: fetch/decode/execute from IR opcode and zero flag.
// Latency: NOP/NOT/BRZ-not-taken 3, ADD/SUB/AND 4, RD/WR/BR/BRZ-taken 5 cycles from S_fet1.
// Backpressure: none; memory is assumed single-cycle. Macro RISC_SPM_ILLEGAL_TRAP_EN traps illegal opcodes in S_halt.
module risc_spm_control_unit
  import risc_spm_pkg::*;
#(
  parameter int ws         = 8,
  parameter int op_size    = 4,
  parameter int state_size = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [ws-1:0] instruction,
  input  logic          zero,
  output logic          load_R0,
  output logic          load_R1,
  output logic          load_R2,
  output logic          load_R3,
  output logic          load_PC,
  output logic          inc_PC,
  output logic          load_IR,
  output logic          load_Add_R,
  output logic          load_Reg_Y,
  output logic          load_Reg_Z,
  output logic [2:0]    sel_Bus_1_Mux,
  output logic [1:0]    sel_Bus_2_Mux,
  output logic          write,
  output logic          halted
);

  logic [state_size-1:0] state;
  logic [state_size-1:0] next_state;
  logic [op_size-1:0]    opcode;
  logic [1:0]            src;
  logic [1:0]            dest;
  logic [3:0]            ld_r;

  assign opcode = instruction[ws-1 -: op_size];
  assign src    = instruction[ws-5 -: 2];
  assign dest   = instruction[ws-7 -: 2];

  assign load_R0 = ld_r[0];
  assign load_R1 = ld_r[1];
  assign load_R2 = ld_r[2];
  assign load_R3 = ld_r[3];

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_idle;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode from state and IR fields; everything is quiet while rst=0
  always_comb begin
    next_state    = S_idle;
    ld_r          = 4'b0000;
    load_PC       = 1'b0;
    inc_PC        = 1'b0;
    load_IR       = 1'b0;
    load_Add_R    = 1'b0;
    load_Reg_Y    = 1'b0;
    load_Reg_Z    = 1'b0;
    sel_Bus_1_Mux = SEL1_R0;
    sel_Bus_2_Mux = SEL2_ALU;
    write         = 1'b0;
    halted        = 1'b0;

    case (state)
      S_idle: next_state = S_fet1;

      S_fet1: begin
        sel_Bus_1_Mux = SEL1_PC;
        sel_Bus_2_Mux = SEL2_BUS1;
        load_Add_R    = 1'b1;
        next_state    = S_fet2;
      end

      S_fet2: begin
        sel_Bus_2_Mux = SEL2_MEM;
        load_IR       = 1'b1;
        inc_PC        = 1'b1;
        next_state    = S_dec;
      end

      S_dec: begin
        case (opcode)
          OP_NOP: next_state = S_fet1;
          OP_ADD, OP_SUB, OP_AND: begin
            sel_Bus_1_Mux = {1'b0, src};
            sel_Bus_2_Mux = SEL2_BUS1;
            load_Reg_Y    = 1'b1;
            next_state    = S_ex1;
          end
          OP_NOT: begin
            sel_Bus_1_Mux = {1'b0, src};
            sel_Bus_2_Mux = SEL2_ALU;
            load_Reg_Z    = 1'b1;
            ld_r          = reg_load_mask(dest);
            next_state    = S_fet1;
          end
          OP_RD, OP_WR, OP_BR: begin
            sel_Bus_1_Mux = SEL1_PC;
            sel_Bus_2_Mux = SEL2_BUS1;
            load_Add_R    = 1'b1;
            next_state    = (opcode == OP_RD) ? S_rd1 :
                            (opcode == OP_WR) ? S_wr1 : S_br1;
          end
          OP_BRZ: begin
            if (zero) begin
              sel_Bus_1_Mux = SEL1_PC;
              sel_Bus_2_Mux = SEL2_BUS1;
              load_Add_R    = 1'b1;
              next_state    = S_br1;
            end else begin
              // Not taken: step PC past the branch target byte
              inc_PC     = 1'b1;
              next_state = S_fet1;
            end
          end
          default: begin
`ifdef RISC_SPM_ILLEGAL_TRAP_EN
            next_state = S_halt;
`else
            next_state = S_fet1;
`endif
          end
        endcase
      end

      S_ex1: begin
        sel_Bus_1_Mux = {1'b0, dest};
        sel_Bus_2_Mux = SEL2_ALU;
        load_Reg_Z    = 1'b1;
        ld_r          = reg_load_mask(dest);
        next_state    = S_fet1;
      end

      S_rd1: begin
        sel_Bus_2_Mux = SEL2_MEM;
        load_Add_R    = 1'b1;
        inc_PC        = 1'b1;
        next_state    = S_rd2;
      end

      S_rd2: begin
        sel_Bus_2_Mux = SEL2_MEM;
        ld_r          = reg_load_mask(dest);
        next_state    = S_fet1;
      end

      S_wr1: begin
        sel_Bus_2_Mux = SEL2_MEM;
        load_Add_R    = 1'b1;
        inc_PC        = 1'b1;
        next_state    = S_wr2;
      end

      S_wr2: begin
        sel_Bus_1_Mux = {1'b0, src};
        write         = 1'b1;
        next_state    = S_fet1;
      end

      S_br1: begin
        sel_Bus_2_Mux = SEL2_MEM;
        load_Add_R    = 1'b1;
        next_state    = S_br2;
      end

      S_br2: begin
        sel_Bus_2_Mux = SEL2_MEM;
        load_PC       = 1'b1;
        next_state    = S_fet1;
      end

      S_halt: begin
`ifdef RISC_SPM_ILLEGAL_TRAP_EN
        halted = 1'b1;
`endif
        next_state = S_halt;
      end

      default: next_state = S_idle;
    endcase

    // Reset overrides the decode so no strobe (e.g. a half-done write) escapes
    if (!rst) begin
      ld_r          = 4'b0000;
      load_PC       = 1'b0;
      inc_PC        = 1'b0;
      load_IR       = 1'b0;
      load_Add_R    = 1'b0;
      load_Reg_Y    = 1'b0;
      load_Reg_Z    = 1'b0;
      sel_Bus_1_Mux = SEL1_R0;
      sel_Bus_2_Mux = SEL2_ALU;
      write         = 1'b0;
      halted        = 1'b0;
    end
  end

endmodule

// File: tb/tb_risc_spm_control_unit.sv
// Directed bench for risc_spm_control_unit: steps instructions through the sequencer.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_risc_spm_control_unit;

  logic       clk;
  logic       rst;
  logic [7:0] instruction;
  logic       zero;
  logic       load_R0, load_R1, load_R2, load_R3;
  logic       load_PC, inc_PC, load_IR, load_Add_R, load_Reg_Y, load_Reg_Z;
  logic [2:0] sel_Bus_1_Mux;
  logic [1:0] sel_Bus_2_Mux;
  logic       write;
  logic       halted;

  int checks = 0;
  int errors = 0;

  risc_spm_control_unit dut (
    .clk           (clk),
    .rst           (rst),
    .instruction   (instruction),
    .zero          (zero),
    .load_R0       (load_R0),
    .load_R1       (load_R1),
    .load_R2       (load_R2),
    .load_R3       (load_R3),
    .load_PC       (load_PC),
    .inc_PC        (inc_PC),
    .load_IR       (load_IR),
    .load_Add_R    (load_Add_R),
    .load_Reg_Y    (load_Reg_Y),
    .load_Reg_Z    (load_Reg_Z),
    .sel_Bus_1_Mux (sel_Bus_1_Mux),
    .sel_Bus_2_Mux (sel_Bus_2_Mux),
    .write         (write),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout: {R3,R2,R1,R0, PC, incPC, IR, AddR, Y, Z, sel1[2:0], sel2[1:0], write, halted}
  function automatic logic [16:0] ev(input logic [3:0] ldr, input logic pc, input logic inc,
                                     input logic ir, input logic ar, input logic y, input logic z,
                                     input logic [2:0] s1, input logic [1:0] s2,
                                     input logic wr, input logic h);
    return {ldr, pc, inc, ir, ar, y, z, s1, s2, wr, h};
  endfunction

  function automatic logic [16:0] obs();
    return {load_R3, load_R2, load_R1, load_R0, load_PC, inc_PC, load_IR, load_Add_R,
            load_Reg_Y, load_Reg_Z, sel_Bus_1_Mux, sel_Bus_2_Mux, write, halted};
  endfunction

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [16:0] QUIET = 17'h0;

  // Walk fet1 and fet2, presenting the new IR while in fet2; leaves the state at S_dec
  task automatic fetch(input string tag, input logic [7:0] ir);
    check({tag, "_fet1"}, obs(), ev(4'b0000, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0));
    tick();
    check({tag, "_fet2"}, obs(), ev(4'b0000, 0, 1, 1, 0, 0, 0, 3'd0, 2'd2, 0, 0));
    instruction = ir;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    instruction = 8'h00;
    zero = 1'b0;
    #1;
    check("rst_async_view", obs(), QUIET);
    tick();
    tick();
    check("rst_held", obs(), QUIET);

    // Release reset: state is S_idle for one cycle
    rst = 1'b1;
    #1;
    check("idle", obs(), QUIET);
    tick();

    // ADD R2 <- R2 + R1 : dec, ex1, back to fet1 (4 cycles)
    fetch("add", 8'h16);
    check("add_dec", obs(), ev(4'b0000, 0, 0, 0, 0, 1, 0, 3'd1, 2'd1, 0, 0));
    tick();
    check("add_ex1", obs(), ev(4'b0100, 0, 0, 0, 0, 0, 1, 3'd2, 2'd0, 0, 0));
    tick();

    // NOT R2 <- ~R3 : single decode cycle
    fetch("not", 8'h4E);
    check("not_dec", obs(), ev(4'b0100, 0, 0, 0, 0, 0, 1, 3'd3, 2'd0, 0, 0));
    tick();

    // NOP
    fetch("nop", 8'h00);
    check("nop_dec", obs(), QUIET);
    tick();

    // RD R3
    fetch("rd", 8'h53);
    check("rd_dec", obs(), ev(4'b0000, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0));
    tick();
    check("rd_rd1", obs(), ev(4'b0000, 0, 1, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
    tick();
    check("rd_rd2", obs(), ev(4'b1000, 0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 0));
    tick();

    // WR from R2: write for exactly one cycle
    fetch("wr", 8'h68);
    check("wr_dec", obs(), ev(4'b0000, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0));
    tick();
    check("wr_wr1", obs(), ev(4'b0000, 0, 1, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
    tick();
    check("wr_wr2", obs(), ev(4'b0000, 0, 0, 0, 0, 0, 0, 3'd2, 2'd0, 1, 0));
    tick();

    // BRZ taken
    zero = 1'b1;
    fetch("brz_t", 8'h80);
    check("brz_t_dec", obs(), ev(4'b0000, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0));
    tick();
    check("brz_t_br1", obs(), ev(4'b0000, 0, 0, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
    tick();
    check("brz_t_br2", obs(), ev(4'b0000, 1, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 0));
    tick();

    // BRZ not taken: skip target byte
    zero = 1'b0;
    fetch("brz_n", 8'h80);
    check("brz_n_dec", obs(), ev(4'b0000, 0, 1, 0, 0, 0, 0, 3'd0, 2'd0, 0, 0));
    tick();

    // Reset during wr1: no write may follow
    fetch("wrrst", 8'h68);
    tick();
    check("wrrst_wr1", obs(), ev(4'b0000, 0, 1, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
    rst = 1'b0;
    #1;
    check("wrrst_forced", obs(), QUIET);
    tick();
    rst = 1'b1;
    #1;
    check("wrrst_idle", obs(), QUIET);
    tick();

    // Illegal opcode
    fetch("ill", 8'hF0);
    check("ill_dec", obs(), QUIET);
    tick();
`ifdef RISC_SPM_ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) begin
      check("ill_halt", obs(), ev(4'b0000, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 1));
      tick();
    end
    rst = 1'b0;
    #1;
    check("halt_rst", obs(), QUIET);
    tick();
    rst = 1'b1;
    #1;
    check("halt_idle", obs(), QUIET);
    tick();
    check("halt_fet1", obs(), ev(4'b0000, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0));
`else
    check("ill_fet1", obs(), ev(4'b0000, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
